// File: rtl/rv16_pkg.sv
// Shared types for the rv16 functional-unit dispatcher.
// Holds the opcode enum, FU index constants and the dispatcher state enum.
package rv16_pkg;

  localparam int NUM_FU = 7;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_XOR = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6
  } fu_op_e;

  localparam int FU_ADD = 0;
  localparam int FU_SUB = 1;
  localparam int FU_MUL = 2;
  localparam int FU_DIV = 3;
  localparam int FU_XOR = 4;
  localparam int FU_AND = 5;
  localparam int FU_OR  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } disp_state_e;

endpackage

// File: rtl/rv16_fu_onehot_dec.sv
// Opcode to one-hot functional-unit select decoder.
// Ports: opcode (4b in), sel (NUM_FU one-hot out), legal (1b out).
module rv16_fu_onehot_dec
  import rv16_pkg::*;
(
  input  logic [3:0]        opcode,
  output logic [NUM_FU-1:0] sel,
  output logic              legal
);

  always_comb begin
    sel   = '0;
    legal = 1'b1;
    unique case (1'b1)
      (opcode == OP_ADD): sel[FU_ADD] = 1'b1;
      (opcode == OP_SUB): sel[FU_SUB] = 1'b1;
      (opcode == OP_MUL): sel[FU_MUL] = 1'b1;
      (opcode == OP_DIV): sel[FU_DIV] = 1'b1;
      (opcode == OP_XOR): sel[FU_XOR] = 1'b1;
      (opcode == OP_AND): sel[FU_AND] = 1'b1;
      (opcode == OP_OR):  sel[FU_OR]  = 1'b1;
      default:            legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv16_fu_dispatch.sv
// Single-instruction dispatcher: routes one ALU op to its FU and returns rd writeback.
// Ports: clk/rst_n; in_* decode handshake; fu_* FU request/ack/done/result;
//        wb_* writeback handshake with error flag; busy while not idle.
module rv16_fu_dispatch
  import rv16_pkg::*;
#(
  parameter int DATA    = 16,
  parameter int REGA    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_opcode,
  input  logic [DATA-1:0]        in_rs1,
  input  logic [DATA-1:0]        in_rs2,
  input  logic [REGA-1:0]        in_rd,
  output logic [NUM_FU-1:0]      fu_req,
  output logic [DATA-1:0]        fu_op_a,
  output logic [DATA-1:0]        fu_op_b,
  input  logic [NUM_FU-1:0]      fu_ack,
  input  logic [NUM_FU-1:0]      fu_done,
  input  logic [NUM_FU*DATA-1:0] fu_res,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [REGA-1:0]        wb_rd,
  output logic [DATA-1:0]        wb_data,
  output logic                   wb_err,
  output logic                   busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  disp_state_e state;
  disp_state_e state_nxt;

  logic [NUM_FU-1:0] dec_sel;
  logic              dec_legal;
  logic [NUM_FU-1:0] sel_q;
  logic [DATA-1:0]   op_a;
  logic [DATA-1:0]   op_b;
  logic [REGA-1:0]   rd_q;
  logic [DATA-1:0]   data_q;
  logic              err_q;
  logic [CW-1:0]     cnt;
  logic [DATA-1:0]   res_mux;
  logic              accept;
  logic              ack_hit;
  logic              done_hit;
  logic              expire;
  logic              inflight;

  // The decoded select is registered at capture,
  // so later states only see the captured opcode.
  rv16_fu_onehot_dec u_dec (
    .opcode (in_opcode),
    .sel    (dec_sel),
    .legal  (dec_legal)
  );

  assign in_ready = rst_n & (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign ack_hit  = |(fu_ack & sel_q);
  assign done_hit = |(fu_done & sel_q);
  assign inflight = (state == ISSUE) | (state == WAIT);
  // cnt holds cycles already spent, so this is
  // the TIMEOUT-th ISSUE/WAIT cycle.
  assign expire   = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    res_mux = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      res_mux |= fu_res[i*DATA +: DATA] & {DATA{sel_q[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fu_req    = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = dec_legal ? ISSUE : WB;
        end
      end
      ISSUE: begin
        fu_req = sel_q;
        if (ack_hit && done_hit) begin
          state_nxt = WB;
        end else if (expire) begin
          state_nxt = WB;
        end else if (ack_hit) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (done_hit || expire) begin
          state_nxt = WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rd_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        sel_q  <= dec_sel;
        op_a   <= in_rs1;
        op_b   <= in_rs2;
        rd_q   <= in_rd;
        data_q <= '0;
        err_q  <= ~dec_legal;
        cnt    <= '0;
      end else if (inflight) begin
        cnt <= cnt + 1'b1;
        // A result arriving on the last allowed
        // cycle still wins over the abort.
        if (done_hit && (state == WAIT || ack_hit)) begin
          data_q <= res_mux;
        end else if (expire) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign fu_op_a  = op_a;
  assign fu_op_b  = op_b;
  assign wb_valid = (state == WB);
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_err   = err_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rv16_fu_dispatch.sv
// Self-checking bench for rv16_fu_dispatch.
// Vector table plus reset-in-flight sequence, scoreboard on writeback.
module tb_rv16_fu_dispatch;

  localparam int DATA = 16;
  localparam int REGA = 3;
  localparam int TMO  = 64;
  localparam int NFU  = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_opcode;
  logic [DATA-1:0] in_rs1;
  logic [DATA-1:0] in_rs2;
  logic [REGA-1:0] in_rd;
  logic [NFU-1:0]  fu_req;
  logic [DATA-1:0] fu_op_a;
  logic [DATA-1:0] fu_op_b;
  logic [NFU-1:0]  fu_ack;
  logic [NFU-1:0]  fu_done;
  logic [NFU*DATA-1:0] fu_res;
  logic            wb_valid;
  logic            wb_ready;
  logic [REGA-1:0] wb_rd;
  logic [DATA-1:0] wb_data;
  logic            wb_err;
  logic            busy;

  always #5 clk = ~clk;

  rv16_fu_dispatch #(
    .DATA(DATA), .REGA(REGA), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_rd(in_rd),
    .fu_req(fu_req), .fu_op_a(fu_op_a),
    .fu_op_b(fu_op_b), .fu_ack(fu_ack),
    .fu_done(fu_done), .fu_res(fu_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy)
  );

  typedef struct {
    logic [3:0]      op;
    logic [DATA-1:0] a;
    logic [DATA-1:0] b;
    logic [REGA-1:0] rd;
    int              ack_dly;
    int              done_dly;
    int              stall;
    bit              noise;
    logic [DATA-1:0] exp_data;
    bit              exp_err;
    int              exp_lat;
  } vec_t;

  typedef struct {
    logic [REGA-1:0] rd;
    logic [DATA-1:0] data;
    logic            err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA-1:0] alu(
    input int op, input logic [DATA-1:0] a,
    input logic [DATA-1:0] b);
    logic [31:0] p;
    case (op)
      0: return a + b;
      1: return a - b;
      2: begin p = a * b; return p[DATA-1:0]; end
      3: return (b != 0) ? a / b : '1;
      4: return a ^ b;
      5: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic vec_t mk(
    input logic [3:0] op, input logic [DATA-1:0] a,
    input logic [DATA-1:0] b, input logic [REGA-1:0] rd,
    input int ad, input int dd, input int st, input bit nz,
    input logic [DATA-1:0] ed, input bit ee, input int el);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd;
    v.ack_dly = ad; v.done_dly = dd; v.stall = st;
    v.noise = nz; v.exp_data = ed; v.exp_err = ee;
    v.exp_lat = el;
    return v;
  endfunction

  task automatic junk_res();
    for (int i = 0; i < NFU; i++)
      fu_res[i*DATA +: DATA] = DATA'($urandom);
  endtask

  task automatic do_op(input vec_t v);
    logic [NFU-1:0] sel;
    bit   legal, acked, done_sent, issuing;
    int   cyc, reqc, waitc, lat, w;
    exp_t e;
    legal = (v.op < 4'd7);
    sel   = legal ? (7'b1 << v.op) : 7'b0;
    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk); w++;
    end
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rs1    = v.a;
    in_rs2    = v.b;
    in_rd     = v.rd;
    e.rd = v.rd; e.data = v.exp_data; e.err = v.exp_err;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_opcode = $urandom;
    in_rs1 = $urandom;
    in_rs2 = $urandom;
    cyc = 1; reqc = 0; waitc = 0; lat = -1;
    acked = 0; done_sent = 0;
    while (cyc < 200) begin
      fu_ack = '0; fu_done = '0;
      junk_res();
      if (wb_valid) begin
        lat = cyc;
        break;
      end
      chk("busy_inflight", {31'b0, busy}, 1);
      issuing = legal && !acked && cyc <= TMO;
      chk("fu_req", {25'b0, fu_req},
          {25'b0, issuing ? sel : 7'b0});
      if (legal) begin
        chk("op_a_hold", {16'b0, fu_op_a}, {16'b0, v.a});
        chk("op_b_hold", {16'b0, fu_op_b}, {16'b0, v.b});
      end
      if (issuing) begin
        reqc++;
        if (reqc > v.ack_dly) begin
          fu_ack = sel; acked = 1;
          if (v.done_dly == 0) begin
            fu_done = sel; done_sent = 1;
            for (int i = 0; i < NFU; i++)
              fu_res[i*DATA +: DATA] = alu(i, v.a, v.b);
          end
        end else if (v.noise) begin
          fu_done = sel;
          fu_ack  = ~sel;
        end
      end else if (acked && !done_sent) begin
        waitc++;
        if (v.done_dly > 0 && waitc == v.done_dly) begin
          fu_done = sel; done_sent = 1;
          for (int i = 0; i < NFU; i++)
            fu_res[i*DATA +: DATA] = alu(i, v.a, v.b);
        end else if (v.noise) begin
          fu_done = ~sel;
          fu_ack  = ~sel;
        end
      end
      @(negedge clk);
      cyc++;
    end
    fu_ack = '0; fu_done = '0;
    if (lat < 0) begin
      chk("wb_never", 0, 1);
      return;
    end
    if (v.exp_lat != 0)
      chk("latency", lat, v.exp_lat);
    chk("fu_req_wb", {25'b0, fu_req}, 0);
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sbq[0];
    for (int s = 0; s < v.stall; s++) begin
      wb_ready = 1'b0;
      chk("stall_valid", {31'b0, wb_valid}, 1);
      chk("stall_in_ready", {31'b0, in_ready}, 0);
      chk("stall_data", {16'b0, wb_data}, {16'b0, e.data});
      chk("stall_rd", {29'b0, wb_rd}, {29'b0, e.rd});
      @(negedge clk);
    end
    wb_ready = 1'b1;
    e = sbq.pop_front();
    chk("wb_in_ready", {31'b0, in_ready}, 0);
    chk("wb_rd", {29'b0, wb_rd}, {29'b0, e.rd});
    chk("wb_data", {16'b0, wb_data}, {16'b0, e.data});
    chk("wb_err", {31'b0, wb_err}, {31'b0, e.err});
    @(negedge clk);
    wb_ready = 1'b0;
    chk("post_valid", {31'b0, wb_valid}, 0);
    chk("post_busy", {31'b0, busy}, 0);
    chk("post_ready", {31'b0, in_ready}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(4'd0, 16'd5, 16'd3, 3'd2,
                 0, 0, 0, 0, 16'd8, 0, 2);
    vecs[1] = mk(4'd3, 16'd100, 16'd7, 3'd4,
                 2, 10, 0, 1, 16'd14, 0, 14);
    vecs[2] = mk(4'hB, 16'd1, 16'd2, 3'd1,
                 0, 0, 0, 0, 16'd0, 1, 1);
    vecs[3] = mk(4'd2, 16'd9, 16'd9, 3'd3,
                 0, -1, 0, 0, 16'd0, 1, TMO + 1);
    vecs[4] = mk(4'd2, 16'd300, 16'd3, 3'd6,
                 1, 3, 5, 1, 16'd900, 0, 6);
    vecs[5] = mk(4'd1, 16'd10, 16'd3, 3'd5,
                 0, 1, 0, 0, 16'd7, 0, 3);
    vecs[6] = mk(4'd5, 16'hF0F0, 16'h3C3C, 3'd7,
                 3, 0, 0, 0, 16'h3030, 0, 5);
    vecs[7] = mk(4'd6, 16'h00F0, 16'h0F00, 3'd0,
                 1000, 0, 0, 0, 16'd0, 1, TMO + 1);
    vecs[8] = mk(4'd4, 16'h1234, 16'h00FF, 3'd1,
                 0, 0, 2, 0, 16'h12CB, 0, 2);

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    fu_ack = '0; fu_done = '0; fu_res = '0;
    wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_fu_req", {25'b0, fu_req}, 0);
    chk("rst_op_a", {16'b0, fu_op_a}, 0);
    chk("rst_op_b", {16'b0, fu_op_b}, 0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("rst_wb_data", {16'b0, wb_data}, 0);
    chk("rst_wb_err", {31'b0, wb_err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_idle_ready", {31'b0, in_ready}, 1);

    for (int i = 0; i < 9; i++)
      do_op(vecs[i]);

    // Reset while a DIV waits for its result.
    in_valid = 1'b1; in_opcode = 4'd3;
    in_rs1 = 16'd50; in_rs2 = 16'd5; in_rd = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_req", {25'b0, fu_req}, 32'h8);
    fu_ack = 7'h8;
    @(negedge clk);
    fu_ack = '0;
    chk("rw_wait_req", {25'b0, fu_req}, 0);
    chk("rw_wait_busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_in_ready", {31'b0, in_ready}, 0);
    chk("rw_fu_req", {25'b0, fu_req}, 0);
    chk("rw_op_a", {16'b0, fu_op_a}, 0);
    chk("rw_op_b", {16'b0, fu_op_b}, 0);
    chk("rw_wb_valid", {31'b0, wb_valid}, 0);
    chk("rw_wb_rd", {29'b0, wb_rd}, 0);
    chk("rw_wb_data", {16'b0, wb_data}, 0);
    chk("rw_wb_err", {31'b0, wb_err}, 0);
    chk("rw_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_ready_after", {31'b0, in_ready}, 1);
    chk("rw_no_wb", {31'b0, wb_valid}, 0);
    do_op(mk(4'd4, 16'hF0F0, 16'h0FF0, 3'd3,
             0, 0, 0, 0, 16'hFF00, 0, 2));

    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
